// File: rtl/lsu.sv
// Load/store stage: consumes the AXI R/B beat for the one instruction in flight,
// aligns and extends load data, and holds the write-back packet until the WBU takes it.
module lsu #(
  parameter int         XLEN    = 32,
  parameter logic [1:0] RESP_OK = 2'b00
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            exu_valid_i,
  output logic            lsu_ready_o,
  input  logic [XLEN-1:0] exu_pc_i,
  input  logic [XLEN-1:0] exu_result_i,
  input  logic [1:0]      exu_addr_mask_i,
  input  logic [3:0]      exu_mem_re_i,
  input  logic            exu_mem_we_i,
  input  logic            exu_res_from_mem_i,
  input  logic            exu_gr_we_i,
  input  logic [4:0]      exu_rd_i,
  input  logic            rvalid_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      rresp_i,
  output logic            rready_o,
  input  logic            bvalid_i,
  input  logic [1:0]      bresp_i,
  output logic            bready_o,
  input  logic            wbu_ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_gr_we_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            wb_fault_o,
  output logic [4:0]      lsu_rd_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    WAIT_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic            accept;
  logic            r_beat;
  logic            b_beat;
  logic [XLEN-1:0] load_data;

  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] result_p1;
  logic [1:0]      mask_p1;
  logic [2:0]      re_p1;
  logic            res_from_mem_p1;
  logic            gr_we_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] data_p1;
  logic            fault_p1;

  // re_hi is mem_re[3:1]: [2] selects a full word, [1] sign-extends, [0] selects a halfword.
  function automatic logic [XLEN-1:0] load_align(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      off,
    input logic [2:0]      re_hi
  );
    logic [15:0]            sh;
    logic signed [XLEN-1:0] ext;
    sh = 16'(rdata >> {off, 3'b000});
    if (re_hi[2]) begin
      ext = rdata;
    end else if (re_hi[0]) begin
      ext = re_hi[1] ? {{(XLEN-16){sh[15]}}, sh} : {{(XLEN-16){1'b0}}, sh};
    end else begin
      ext = re_hi[1] ? {{(XLEN-8){sh[7]}}, sh[7:0]} : {{(XLEN-8){1'b0}}, sh[7:0]};
    end
    return $unsigned(ext);
  endfunction

  function automatic state_e dispatch(input logic [3:0] re, input logic we);
    if (|re)    return WAIT_R;
    else if (we) return WAIT_B;
    else        return DONE;
  endfunction

  assign lsu_ready_o = (state_q == IDLE) | ((state_q == DONE) & wbu_ready_i);
  assign accept      = exu_valid_i & lsu_ready_o;
  assign rready_o    = (state_q == WAIT_R);
  assign bready_o    = (state_q == WAIT_B);
  assign r_beat      = rready_o & rvalid_i;
  assign b_beat      = bready_o & bvalid_i;
  assign valid_o     = (state_q == DONE);
  assign load_data   = load_align(rdata_i, mask_p1, re_p1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = dispatch(exu_mem_re_i, exu_mem_we_i);
      WAIT_R: if (rvalid_i) state_d = DONE;
      WAIT_B: if (bvalid_i) state_d = DONE;
      DONE: begin
        if (accept)           state_d = dispatch(exu_mem_re_i, exu_mem_we_i);
        else if (wbu_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: packet latched at accept, completed by the R/B beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_p1           <= '0;
      result_p1       <= '0;
      mask_p1         <= '0;
      re_p1           <= '0;
      res_from_mem_p1 <= 1'b0;
      gr_we_p1        <= 1'b0;
      rd_p1           <= '0;
      data_p1         <= '0;
      fault_p1        <= 1'b0;
    end else begin
      if (accept) begin
        pc_p1           <= exu_pc_i;
        result_p1       <= exu_result_i;
        mask_p1         <= exu_addr_mask_i;
        re_p1           <= exu_mem_re_i[3:1];
        res_from_mem_p1 <= exu_res_from_mem_i;
        gr_we_p1        <= exu_gr_we_i;
        rd_p1           <= exu_rd_i;
        data_p1         <= exu_result_i;
        fault_p1        <= 1'b0;
      end
      if (r_beat) begin
        data_p1  <= res_from_mem_p1 ? load_data : result_p1;
        fault_p1 <= (rresp_i != RESP_OK);
      end
      if (b_beat) begin
        data_p1  <= result_p1;
        fault_p1 <= (bresp_i != RESP_OK);
      end
    end
  end

  assign wb_pc_o    = pc_p1;
  assign wb_rd_o    = rd_p1;
  assign wb_data_o  = data_p1;
  assign wb_fault_o = fault_p1;
  assign wb_gr_we_o = gr_we_p1 & ~fault_p1;
  assign lsu_rd_o   = (state_q == IDLE) ? 5'd0 : rd_p1;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: reset, directed vector table, hand sequences for back-to-back,
// stall and mid-transaction reset, then random ops against an arithmetic model.
module tb_lsu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exu_valid_i = 1'b0;
  logic        lsu_ready_o;
  logic [31:0] exu_pc_i = '0;
  logic [31:0] exu_result_i = '0;
  logic [1:0]  exu_addr_mask_i = '0;
  logic [3:0]  exu_mem_re_i = '0;
  logic        exu_mem_we_i = 1'b0;
  logic        exu_res_from_mem_i = 1'b0;
  logic        exu_gr_we_i = 1'b0;
  logic [4:0]  exu_rd_i = '0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  logic        rready_o;
  logic        bvalid_i = 1'b0;
  logic [1:0]  bresp_i = '0;
  logic        bready_o;
  logic        wbu_ready_i = 1'b1;
  logic        valid_o;
  logic [31:0] wb_pc_o;
  logic [4:0]  wb_rd_o;
  logic        wb_gr_we_o;
  logic [31:0] wb_data_o;
  logic        wb_fault_o;
  logic [4:0]  lsu_rd_o;

  int total = 0;
  int bad   = 0;

  lsu #(.XLEN(32), .RESP_OK(2'b00)) dut (
    .clock(clock), .reset(reset),
    .exu_valid_i(exu_valid_i), .lsu_ready_o(lsu_ready_o),
    .exu_pc_i(exu_pc_i), .exu_result_i(exu_result_i),
    .exu_addr_mask_i(exu_addr_mask_i), .exu_mem_re_i(exu_mem_re_i),
    .exu_mem_we_i(exu_mem_we_i), .exu_res_from_mem_i(exu_res_from_mem_i),
    .exu_gr_we_i(exu_gr_we_i), .exu_rd_i(exu_rd_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
    .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
    .wbu_ready_i(wbu_ready_i), .valid_o(valid_o),
    .wb_pc_o(wb_pc_o), .wb_rd_o(wb_rd_o), .wb_gr_we_o(wb_gr_we_o),
    .wb_data_o(wb_data_o), .wb_fault_o(wb_fault_o), .lsu_rd_o(lsu_rd_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference load value from the plain arithmetic meaning of each load type.
  function automatic logic [31:0] ref_load(input logic [3:0] re, input logic [1:0] m,
                                           input logic [31:0] rd);
    longint unsigned shifted;
    longint v;
    shifted = longint'(rd) / (longint'(1) << (8 * m));
    case (re)
      4'b1111: v = longint'(rd);
      4'b0111: begin v = shifted % 65536; if (v >= 32768) v = v - 65536; end
      4'b0011: v = shifted % 65536;
      4'b0101: begin v = shifted % 256; if (v >= 128) v = v - 256; end
      default: v = shifted % 256;
    endcase
    return 32'(v);
  endfunction

  task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [1:0] m,
                       input logic [3:0] re, input logic we, input logic [4:0] rd,
                       input logic gwe, input string tag);
    exu_pc_i = pc; exu_result_i = res; exu_addr_mask_i = m; exu_mem_re_i = re;
    exu_mem_we_i = we; exu_res_from_mem_i = (re != 4'b0); exu_gr_we_i = gwe; exu_rd_i = rd;
    exu_valid_i = 1'b1;
    #1;
    chk({tag, ".ready"}, lsu_ready_o, 1'b1);
    tick();
    exu_valid_i = 1'b0;
  endtask

  // One complete instruction: accept, optional response wait, retire after stall cycles.
  task automatic run(input logic [3:0] re, input logic we, input logic [1:0] m,
                     input logic [31:0] res, input logic [31:0] rdata, input logic [1:0] resp,
                     input int delay, input int stall, input logic [31:0] exp_data,
                     input logic exp_fault, input logic [4:0] rd, input string tag);
    logic [31:0] pc;
    pc = $urandom;
    issue(pc, res, m, re, we, rd, 1'b1, tag);
    if (re != 4'b0 || we) begin
      for (int d = 0; d < delay; d++) begin
        chk({tag, ".rready"}, rready_o, re != 4'b0);
        chk({tag, ".bready"}, bready_o, re == 4'b0);
        chk({tag, ".wait_valid"}, valid_o, 1'b0);
        chk({tag, ".wait_lsu_rd"}, lsu_rd_o, rd);
        tick();
      end
      if (re != 4'b0) begin rvalid_i = 1'b1; rdata_i = rdata; rresp_i = resp; end
      else begin bvalid_i = 1'b1; bresp_i = resp; end
      tick();
      rvalid_i = 1'b0; bvalid_i = 1'b0; rdata_i = $urandom;
    end
    for (int s = 0; s <= stall; s++) begin
      wbu_ready_i = (s == stall);
      #1;
      chk({tag, ".valid"}, valid_o, 1'b1);
      chk({tag, ".data"}, wb_data_o, exp_data);
      chk({tag, ".fault"}, wb_fault_o, exp_fault);
      chk({tag, ".gr_we"}, wb_gr_we_o, !exp_fault);
      chk({tag, ".rd"}, wb_rd_o, rd);
      chk({tag, ".pc"}, wb_pc_o, pc);
      chk({tag, ".lsu_rd"}, lsu_rd_o, rd);
      chk({tag, ".ready_done"}, lsu_ready_o, s == stall);
      chk({tag, ".no_rready"}, rready_o, 1'b0);
      tick();
    end
    wbu_ready_i = 1'b1;
    chk({tag, ".idle_valid"}, valid_o, 1'b0);
    chk({tag, ".idle_lsu_rd"}, lsu_rd_o, 5'd0);
  endtask

  typedef struct {
    logic [3:0]  re;
    logic        we;
    logic [1:0]  mask;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          delay;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] load_types[5] = '{4'b1111, 4'b0111, 4'b0011, 4'b0101, 4'b0001};

  initial begin
    // Reset state
    #2;
    chk("rst.valid", valid_o, 1'b0);
    chk("rst.rready", rready_o, 1'b0);
    chk("rst.bready", bready_o, 1'b0);
    chk("rst.fault", wb_fault_o, 1'b0);
    chk("rst.gr_we", wb_gr_we_o, 1'b0);
    chk("rst.data", wb_data_o, 32'h0);
    chk("rst.pc", wb_pc_o, 32'h0);
    chk("rst.rd", wb_rd_o, 5'd0);
    chk("rst.lsu_rd", lsu_rd_o, 5'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst.ready", lsu_ready_o, 1'b1);

    // ALU pass-through and back-to-back
    exu_pc_i = 32'h100; exu_result_i = 32'h12345678; exu_rd_i = 5'd5; exu_gr_we_i = 1'b1;
    exu_mem_re_i = 4'b0; exu_mem_we_i = 1'b0; exu_res_from_mem_i = 1'b0;
    exu_valid_i = 1'b1; wbu_ready_i = 1'b1;
    tick();
    chk("alu.valid", valid_o, 1'b1);
    chk("alu.data", wb_data_o, 32'h12345678);
    chk("alu.rd", wb_rd_o, 5'd5);
    chk("alu.gr_we", wb_gr_we_o, 1'b1);
    chk("alu.b2b_ready", lsu_ready_o, 1'b1);
    exu_pc_i = 32'h104; exu_result_i = 32'hCAFEF00D; exu_rd_i = 5'd9;
    tick();
    exu_valid_i = 1'b0;
    chk("b2b.valid", valid_o, 1'b1);
    chk("b2b.data", wb_data_o, 32'hCAFEF00D);
    chk("b2b.pc", wb_pc_o, 32'h104);
    chk("b2b.rd", wb_rd_o, 5'd9);
    tick();
    chk("b2b.drop", valid_o, 1'b0);

    // Directed load/store vectors
    vecs.push_back('{4'b0101, 1'b0, 2'd2, 32'h00A50000, 2'b00, 0, 32'hFFFFFFA5, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 2'd2, 32'h00A50000, 2'b00, 0, 32'h000000A5, 1'b0});
    vecs.push_back('{4'b0111, 1'b0, 2'd2, 32'h80011234, 2'b00, 1, 32'hFFFF8001, 1'b0});
    vecs.push_back('{4'b0011, 1'b0, 2'd2, 32'h80011234, 2'b00, 0, 32'h00008001, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd0, 32'hDEADBEEF, 2'b00, 4, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd2, 32'h11223344, 2'b00, 0, 32'h11223344, 1'b0});
    vecs.push_back('{4'b0111, 1'b0, 2'd3, 32'hF0123456, 2'b00, 0, 32'h000000F0, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 2'd1, 32'h00008000, 2'b00, 2, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 2'd0, 32'hDEADBEEF, 2'b11, 0, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{4'b0001, 1'b1, 2'd3, 32'h7F000000, 2'b00, 1, 32'h0000007F, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 2'd0, 32'h0, 2'b10, 2, 32'h55AA55AA, 1'b1});
    vecs.push_back('{4'b0000, 1'b1, 2'd0, 32'h0, 2'b00, 0, 32'h55AA55AA, 1'b0});
    foreach (vecs[i])
      run(vecs[i].re, vecs[i].we, vecs[i].mask, 32'h55AA55AA, vecs[i].rdata, vecs[i].resp,
          vecs[i].delay, 0, vecs[i].exp_data, vecs[i].exp_fault, 5'(i + 1), $sformatf("vec%0d", i));

    // Store with OK response held by a 3-cycle write-back stall
    run(4'b0000, 1'b1, 2'd0, 32'h0BADF00D, 32'h0, 2'b00, 1, 3, 32'h0BADF00D, 1'b0, 5'd7, "st_stall");

    // Reset while waiting for a pending R beat
    issue(32'h200, 32'h0, 2'd0, 4'b1111, 1'b0, 5'd12, 1'b1, "rstmid");
    rvalid_i = 1'b1; rdata_i = 32'h13572468;
    #1;
    chk("rstmid.rready_before", rready_o, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid.valid", valid_o, 1'b0);
    chk("rstmid.rready", rready_o, 1'b0);
    chk("rstmid.lsu_rd", lsu_rd_o, 5'd0);
    chk("rstmid.ready", lsu_ready_o, 1'b1);
    tick();
    rvalid_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstmid.after_ready", lsu_ready_o, 1'b1);
    chk("rstmid.after_valid", valid_o, 1'b0);
    chk("rstmid.after_data", wb_data_o, 32'h0);

    // Random instructions against the model
    for (int i = 0; i < 150; i++) begin
      int kind;
      logic [3:0]  re;
      logic [1:0]  m;
      logic [31:0] res, rd;
      logic [1:0]  resp;
      kind = $urandom_range(0, 2);
      m    = 2'($urandom_range(0, 3));
      res  = $urandom;
      rd   = $urandom;
      resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      re   = (kind == 0) ? load_types[$urandom_range(0, 4)] : 4'b0000;
      if (kind == 2) resp = 2'b00;
      run(re, kind == 1, m, res, rd, resp, $urandom_range(0, 3), $urandom_range(0, 2),
          (kind == 0) ? ref_load(re, m, rd) : res, resp != 2'b00,
          5'($urandom_range(0, 31)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
